mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter sitting directly below the processor's instruction-fetch and memory stages. It accepts word requests from the fetch port (read-only) and the data port (read/write with byte enables), and serialises them onto a single request/acknowledge memory bus. Data requests take priority, with a starvation guard for fetch. Responses go back to the originating port as a one-cycle acknowledge with registered read data.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) to single request-ack memory bus arbiter with data priority and a fetch starvation guard.
// Optional bus timeout with error response: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iIReq,
    input  logic [31:0] iIAddr,
    output logic        oIAck,
    output logic [31:0] oIRdata,
    output logic        oIErr,
    input  logic        iDReq,
    input  logic        iDWe,
    input  logic [31:0] iDAddr,
    input  logic [31:0] iDWdata,
    input  logic [3:0]  iDBe,
    output logic        oDAck,
    output logic [31:0] oDRdata,
    output logic        oDErr,
    output logic        oMReq,
    output logic        oMWe,
    output logic [31:0] oMAddr,
    output logic [31:0] oMWdata,
    output logic [3:0]  oMBe,
    input  logic        iMAck,
    input  logic [31:0] iMRdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  starve_q;
    logic        oIAck_q, oDAck_q, oMReq_q, oMWe_q;
    logic [31:0] oIRdata_q, oDRdata_q, oMAddr_q, oMWdata_q;
    logic [3:0]  oMBe_q;
    logic        i_elig_d, d_elig_d, grant_d_d, grant_i_d;

    // A port still showing its acknowledge has not yet had a chance to drop its request.
    always_comb begin
        i_elig_d  = iIReq && !oIAck_q;
        d_elig_d  = iDReq && !oDAck_q;
        grant_d_d = d_elig_d && (!i_elig_d || ({28'd0, starve_q} < STARVE_LIMIT));
        grant_i_d = !grant_d_d && i_elig_d;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] tmo_q;
    logic       oIErr_q, oDErr_q;
    logic       unused_ok;
    assign unused_ok = ^{iIAddr[1:0], iDAddr[1:0]};
`else
    logic unused_ok;
    assign unused_ok = ^{iIAddr[1:0], iDAddr[1:0], TIMEOUT_CYCLES};
`endif

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            oIAck_q   <= 1'b0;
            oDAck_q   <= 1'b0;
            oIRdata_q <= '0;
            oDRdata_q <= '0;
            oMReq_q   <= 1'b0;
            oMWe_q    <= 1'b0;
            oMAddr_q  <= '0;
            oMWdata_q <= '0;
            oMBe_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q     <= '0;
            oIErr_q   <= 1'b0;
            oDErr_q   <= 1'b0;
`endif
        end else begin
            oIAck_q <= 1'b0;
            oDAck_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            oIErr_q <= 1'b0;
            oDErr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_q <= '0;
`endif
                    if (grant_d_d) begin
                        oMReq_q   <= 1'b1;
                        oMWe_q    <= iDWe;
                        oMAddr_q  <= {iDAddr[31:2], 2'b00};
                        oMWdata_q <= iDWdata;
                        oMBe_q    <= iDBe;
                        state_q   <= BUSY_D;
                        if (!iIReq)
                            starve_q <= '0;
                        else if (starve_q != 4'hF)
                            starve_q <= starve_q + 4'd1;
                    end else if (grant_i_d) begin
                        oMReq_q  <= 1'b1;
                        oMWe_q   <= 1'b0;
                        oMAddr_q <= {iIAddr[31:2], 2'b00};
                        oMBe_q   <= 4'hF;
                        state_q  <= BUSY_I;
                        starve_q <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (iMAck) begin
                        oMReq_q <= 1'b0;
                        state_q <= IDLE;
                        if (state_q == BUSY_I) begin
                            oIRdata_q <= iMRdata;
                            oIAck_q   <= 1'b1;
                        end else begin
                            oDRdata_q <= oMWe_q ? '0 : iMRdata;
                            oDAck_q   <= 1'b1;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        oMReq_q <= 1'b0;
                        state_q <= IDLE;
                        if (state_q == BUSY_I) begin
                            oIRdata_q <= '0;
                            oIAck_q   <= 1'b1;
                            oIErr_q   <= 1'b1;
                        end else begin
                            oDRdata_q <= '0;
                            oDAck_q   <= 1'b1;
                            oDErr_q   <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oIAck   = oIAck_q;
    assign oIRdata = oIRdata_q;
    assign oDAck   = oDAck_q;
    assign oDRdata = oDRdata_q;
    assign oMReq   = oMReq_q;
    assign oMWe    = oMWe_q;
    assign oMAddr  = oMAddr_q;
    assign oMWdata = oMWdata_q;
    assign oMBe    = oMBe_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign oIErr   = oIErr_q;
    assign oDErr   = oDErr_q;
`else
    assign oIErr   = 1'b0;
    assign oDErr   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus grants and port responses are queued at stimulus time.
// Timeout scenario is exercised when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

    logic        iClk = 1'b0;
    logic        nRst;
    logic        iIReq, iDReq, iDWe, iMAck;
    logic [31:0] iIAddr, iDAddr, iDWdata, iMRdata;
    logic [3:0]  iDBe;
    logic        oIAck, oIErr, oDAck, oDErr, oMReq, oMWe;
    logic [31:0] oIRdata, oDRdata, oMAddr, oMWdata;
    logic [3:0]  oMBe;

    always #5 iClk = ~iClk;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(10)) dut (
        .iClk(iClk), .nRst(nRst),
        .iIReq(iIReq), .iIAddr(iIAddr), .oIAck(oIAck), .oIRdata(oIRdata), .oIErr(oIErr),
        .iDReq(iDReq), .iDWe(iDWe), .iDAddr(iDAddr), .iDWdata(iDWdata), .iDBe(iDBe),
        .oDAck(oDAck), .oDRdata(oDRdata), .oDErr(oDErr),
        .oMReq(oMReq), .oMWe(oMWe), .oMAddr(oMAddr), .oMWdata(oMWdata), .oMBe(oMBe),
        .iMAck(iMAck), .iMRdata(iMRdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    bus_t grant_q[$];
    rsp_t i_q[$];
    rsp_t d_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mem_lat  = 0;
    bit   mem_on   = 1'b1;
    bit   force_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h0F0F1234);
    endfunction

    task automatic tick();
        @(negedge iClk);
    endtask

    // Memory: acks after mem_lat extra busy cycles; force_ack drives a stray ack.
    initial begin
        int busy_cnt = 0;
        iMAck = 1'b0;
        iMRdata = '0;
        forever begin
            @(negedge iClk);
            iMAck = 1'b0;
            iMRdata = '0;
            if (oMReq && nRst) begin
                busy_cnt++;
                if (mem_on && busy_cnt > mem_lat) begin
                    iMAck = 1'b1;
                    iMRdata = mem_word(oMAddr);
                end
            end else begin
                busy_cnt = 0;
            end
            if (force_ack) begin
                iMAck = 1'b1;
                iMRdata = 32'hCAFEF00D;
            end
        end
    end

    // Monitor: grants in order, bus stability during a transaction, responses per port.
    initial begin
        bus_t cur, eb;
        rsp_t r;
        bit prev = 1'b0;
        forever begin
            @(negedge iClk);
            if (oMReq && !prev) begin
                if (grant_q.size() == 0) begin
                    check("grant_unexpected", oMAddr, 32'hFFFFFFFF);
                end else begin
                    eb = grant_q.pop_front();
                    check("grant_addr", oMAddr, eb.addr);
                    check("grant_we_be", {27'd0, oMWe, oMBe}, {27'd0, eb.we, eb.be});
                    if (eb.we) check("grant_wdata", oMWdata, eb.wdata);
                end
                cur.we = oMWe; cur.addr = oMAddr; cur.wdata = oMWdata; cur.be = oMBe;
            end else if (oMReq && prev) begin
                check("bus_stable_addr", oMAddr, cur.addr);
                check("bus_stable_wdata", oMWdata, cur.wdata);
                check("bus_stable_ctl", {27'd0, oMWe, oMBe}, {27'd0, cur.we, cur.be});
            end
            prev = oMReq;
            if (oIAck) begin
                if (i_q.size() == 0) check("i_ack_unexpected", 32'd1, 32'd0);
                else begin
                    r = i_q.pop_front();
                    check("i_rdata", oIRdata, r.rdata);
                    check("i_err", {31'd0, oIErr}, {31'd0, r.err});
                end
            end
            if (oDAck) begin
                if (d_q.size() == 0) check("d_ack_unexpected", 32'd1, 32'd0);
                else begin
                    r = d_q.pop_front();
                    check("d_rdata", oDRdata, r.rdata);
                    check("d_err", {31'd0, oDErr}, {31'd0, r.err});
                end
            end
        end
    end

    task automatic wait_ack(input bit is_d, input int max, output int n);
        n = 0;
        while (!(is_d ? oDAck : oIAck) && n < max) begin
            tick();
            n++;
        end
        if (!(is_d ? oDAck : oIAck)) check(is_d ? "d_ack_timeout" : "i_ack_timeout", 32'd0, 32'd1);
    endtask

    // Both ports raise together; a losing fetch withdraws after the data grant.
    task automatic starve_round(input bit expect_d, input int k);
        int n;
        iIReq = 1'b1; iIAddr = 32'h600 + 32'(k * 16);
        iDReq = 1'b1; iDWe = 1'b0; iDAddr = 32'h700 + 32'(k * 16); iDBe = 4'hF;
        if (expect_d) begin
            grant_q.push_back('{1'b0, 32'h700 + 32'(k * 16), 32'd0, 4'hF});
            d_q.push_back('{mem_word(32'h700 + 32'(k * 16)), 1'b0});
            tick();
            iIReq = 1'b0;
            wait_ack(1'b1, 10, n);
            iDReq = 1'b0;
        end else begin
            grant_q.push_back('{1'b0, 32'h600 + 32'(k * 16), 32'd0, 4'hF});
            i_q.push_back('{mem_word(32'h600 + 32'(k * 16)), 1'b0});
            grant_q.push_back('{1'b0, 32'h700 + 32'(k * 16), 32'd0, 4'hF});
            d_q.push_back('{mem_word(32'h700 + 32'(k * 16)), 1'b0});
            wait_ack(1'b0, 10, n);
            iIReq = 1'b0;
            wait_ack(1'b1, 10, n);
            iDReq = 1'b0;
        end
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        nRst = 1'b0;
        iIReq = 1'b0; iIAddr = '0; iDReq = 1'b0; iDWe = 1'b0;
        iDAddr = '0; iDWdata = '0; iDBe = '0;
        repeat (3) tick();
        check("rst_mreq", {31'd0, oMReq}, 32'd0);
        check("rst_mwe", {31'd0, oMWe}, 32'd0);
        check("rst_maddr", oMAddr, 32'd0);
        check("rst_mwdata", oMWdata, 32'd0);
        check("rst_mbe", {28'd0, oMBe}, 32'd0);
        check("rst_acks", {29'd0, oIAck, oDAck, oIErr | oDErr}, 32'd0);
        check("rst_irdata", oIRdata, 32'd0);
        check("rst_drdata", oDRdata, 32'd0);
        nRst = 1'b1;
        tick();

        // Single fetch, unaligned address, immediate memory ack
        mem_lat = 0;
        iIReq = 1'b1; iIAddr = 32'h103;
        grant_q.push_back('{1'b0, 32'h100, 32'd0, 4'hF});
        i_q.push_back('{32'hDEADBEEF, 1'b0});
        tick();
        check("fetch_mreq", {31'd0, oMReq}, 32'd1);
        check("fetch_ack_early", {31'd0, oIAck}, 32'd0);
        tick();
        check("fetch_ack_latency", {31'd0, oIAck}, 32'd1);
        iIReq = 1'b0;
        tick();
        check("fetch_ack_single", {31'd0, oIAck}, 32'd0);

        // Data write with delayed ack; inputs scrambled after grant must be ignored
        mem_lat = 5;
        iDReq = 1'b1; iDWe = 1'b1; iDAddr = 32'h2000; iDWdata = 32'h12345678; iDBe = 4'b0011;
        grant_q.push_back('{1'b1, 32'h2000, 32'h12345678, 4'b0011});
        d_q.push_back('{32'd0, 1'b0});
        tick();
        iDAddr = 32'hFFFFFFF0; iDWdata = 32'hBAD0BAD0; iDBe = 4'hC; iDWe = 1'b0;
        wait_ack(1'b1, 20, n);
        check("write_latency", n, 32'd6);
        iDReq = 1'b0;
        tick();

        // Data read, unaligned
        mem_lat = 2;
        iDReq = 1'b1; iDWe = 1'b0; iDAddr = 32'h41; iDBe = 4'b1100;
        grant_q.push_back('{1'b0, 32'h40, 32'd0, 4'b1100});
        d_q.push_back('{mem_word(32'h40), 1'b0});
        wait_ack(1'b1, 20, n);
        check("read_latency", n, 32'd4);
        iDReq = 1'b0;
        tick();

        // Data request still high in its ack cycle: the pending fetch must win
        mem_lat = 0;
        iIReq = 1'b1; iIAddr = 32'h300;
        iDReq = 1'b1; iDWe = 1'b0; iDAddr = 32'h500; iDBe = 4'hF;
        grant_q.push_back('{1'b0, 32'h500, 32'd0, 4'hF});
        grant_q.push_back('{1'b0, 32'h300, 32'd0, 4'hF});
        d_q.push_back('{mem_word(32'h500), 1'b0});
        i_q.push_back('{mem_word(32'h300), 1'b0});
        tick();
        tick();
        check("same_cycle_dack", {31'd0, oDAck}, 32'd1);
        tick();
        check("same_cycle_grant_i", oMAddr, 32'h300);
        iDReq = 1'b0;
        tick();
        check("same_cycle_iack", {31'd0, oIAck}, 32'd1);
        iIReq = 1'b0;
        tick();

        // Three data wins with fetch waiting, then reset mid-transaction on the fourth
        for (int k = 0; k < 3; k++) starve_round(1'b1, k);
        mem_on = 1'b0;
        iIReq = 1'b1; iIAddr = 32'hA00;
        iDReq = 1'b1; iDWe = 1'b1; iDAddr = 32'h800; iDWdata = 32'h55AA55AA; iDBe = 4'hF;
        grant_q.push_back('{1'b1, 32'h800, 32'h55AA55AA, 4'hF});
        tick();
        tick();
        check("rst_mid_mreq_before", {31'd0, oMReq}, 32'd1);
        #2 nRst = 1'b0;
        #1 check("rst_mid_mreq_async", {31'd0, oMReq}, 32'd0);
        iIReq = 1'b0; iDReq = 1'b0;
        tick();
        tick();
        check("rst_mid_no_dack", {31'd0, oDAck}, 32'd0);
        nRst = 1'b1;
        mem_on = 1'b1;
        tick();

        // Counter restarted at zero: four data wins, then the fetch
        for (int k = 0; k < 4; k++) starve_round(1'b1, k + 8);
        starve_round(1'b0, 12);

`ifdef MEM_ARB_TIMEOUT_EN
        mem_on = 1'b0;
        iIReq = 1'b1; iIAddr = 32'h904;
        grant_q.push_back('{1'b0, 32'h904, 32'd0, 4'hF});
        i_q.push_back('{32'd0, 1'b1});
        wait_ack(1'b0, 40, n);
        check("timeout_cycles", n, 32'd11);
        check("timeout_mreq_drop", {31'd0, oMReq}, 32'd0);
        iIReq = 1'b0;
        mem_on = 1'b1;
`else
        mem_lat = 12;
        iIReq = 1'b1; iIAddr = 32'h904;
        grant_q.push_back('{1'b0, 32'h904, 32'd0, 4'hF});
        i_q.push_back('{mem_word(32'h904), 1'b0});
        wait_ack(1'b0, 40, n);
        check("slow_fetch_latency", n, 32'd14);
        iIReq = 1'b0;
        mem_lat = 0;
`endif
        // Stray memory ack while idle must be ignored
        force_ack = 1'b1;
        tick();
        tick();
        force_ack = 1'b0;
        check("idle_ack_ignored", {30'd0, oIAck, oDAck}, 32'd0);
        check("idle_ack_no_mreq", {31'd0, oMReq}, 32'd0);
        repeat (3) tick();

        check("left_grants", grant_q.size(), 32'd0);
        check("left_i_rsp", i_q.size(), 32'd0);
        check("left_d_rsp", d_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
